// File: rtl/data_ram_arbiter_if.sv
// Bus bundle between the two requesters (CPU datapath, DMA loader), the
// arbiter and data_ram. The master modport is the requester/RAM side; the slave modport is the arbiter.
interface data_ram_arbiter_if #(
  parameter int DW = 24,
  parameter int AW = 12
);
  logic          cpu_req;
  logic          cpu_rnw;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_rnw;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_ack;
  logic [DW-1:0] dma_rdata;

  logic          mem_cs;
  logic          mem_rnw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    input  dma_req, dma_rnw, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    output mem_cs, mem_rnw, mem_addr, mem_wdata,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_rnw, cpu_addr, cpu_wdata,
    output dma_req, dma_rnw, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, dma_ack, dma_rdata,
    input  mem_cs, mem_rnw, mem_addr, mem_wdata,
    input  busy, owner
  );
endinterface

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter in front of the single-port data_ram (CPU datapath vs DMA loader).
// Define ARB_CPU_PRIORITY_EN for fixed CPU priority; otherwise round-robin on ties.
module data_ram_arbiter #(
  parameter int DATA_BUS_WIDTH    = 24,
  parameter int ADDRESS_BUS_WIDTH = 12,
  parameter int ACCESS_CYCLES     = 2
) (
  input  logic                mainClock,
  input  logic                reset,
  data_ram_arbiter_if.slave   io_bus
);
  localparam int DW = DATA_BUS_WIDTH;
  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic          r_rnw;
  logic          r_owner;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_dma_rdata;
  logic          w_any_req;
  logic          w_grant_dma;

  assign w_any_req = io_bus.cpu_req | io_bus.dma_req;

`ifdef ARB_CPU_PRIORITY_EN
  assign w_grant_dma = io_bus.dma_req & ~io_bus.cpu_req;
`else
  // On a tie the port that did not own the last access wins.
  assign w_grant_dma = io_bus.dma_req & (~io_bus.cpu_req | ~r_owner);
`endif

  // NOTE: every output of the combinational block gets a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req) w_next = S_ACCESS;
      S_ACCESS: if (r_cnt == 4'd0) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      r_cnt       <= 4'd0;
      r_rnw       <= 1'b1;
      r_owner     <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant_dma;
            r_rnw   <= w_grant_dma ? io_bus.dma_rnw   : io_bus.cpu_rnw;
            r_addr  <= w_grant_dma ? io_bus.dma_addr  : io_bus.cpu_addr;
            r_wdata <= w_grant_dma ? io_bus.dma_wdata : io_bus.cpu_wdata;
            r_cnt   <= CNT_INIT;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (r_rnw) begin
            if (r_owner) r_dma_rdata <= io_bus.mem_rdata;
            else         r_cpu_rdata <= io_bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Chip select and acks decode from state, so an async reset drops them at once.
  assign io_bus.mem_cs    = (r_state == S_ACCESS);
  assign io_bus.mem_rnw   = r_rnw;
  assign io_bus.mem_addr  = r_addr;
  assign io_bus.mem_wdata = r_wdata;
  assign io_bus.cpu_ack   = (r_state == S_DONE) & ~r_owner;
  assign io_bus.dma_ack   = (r_state == S_DONE) &  r_owner;
  assign io_bus.cpu_rdata = r_cpu_rdata;
  assign io_bus.dma_rdata = r_dma_rdata;
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.owner     = r_owner;
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter: one instance with ACCESS_CYCLES=2, one with 1,
// each in front of a small behavioural RAM with combinational read.
module tb_data_ram_arbiter;
`ifdef ARB_CPU_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic mainClock = 1'b0;
  logic reset     = 1'b0;
  int   n_checks  = 0;
  int   n_pass    = 0;
  logic exp_d;

  always #5 mainClock = ~mainClock;

  data_ram_arbiter_if #(.DW(24), .AW(12)) m0 ();
  data_ram_arbiter_if #(.DW(24), .AW(12)) m1 ();

  data_ram_arbiter #(.DATA_BUS_WIDTH(24), .ADDRESS_BUS_WIDTH(12), .ACCESS_CYCLES(2)) u_dut0 (
    .mainClock (mainClock), .reset (reset), .io_bus (m0));
  data_ram_arbiter #(.DATA_BUS_WIDTH(24), .ADDRESS_BUS_WIDTH(12), .ACCESS_CYCLES(1)) u_dut1 (
    .mainClock (mainClock), .reset (reset), .io_bus (m1));

  logic [23:0] ram0 [4096];
  logic [23:0] ram1 [4096];
  assign m0.mem_rdata = ram0[m0.mem_addr];
  assign m1.mem_rdata = ram1[m1.mem_addr];

  // Only writes touch the arrays here and the arbiter only samples on reads, so no race.
  always @(posedge mainClock) begin
    if (m0.mem_cs && !m0.mem_rnw) ram0[m0.mem_addr] = m0.mem_wdata;
    if (m1.mem_cs && !m1.mem_rnw) ram1[m1.mem_addr] = m1.mem_wdata;
  end

  task automatic tick();
    @(posedge mainClock);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    m0.cpu_req = 0; m0.cpu_rnw = 1; m0.cpu_addr = '0; m0.cpu_wdata = '0;
    m0.dma_req = 0; m0.dma_rnw = 1; m0.dma_addr = '0; m0.dma_wdata = '0;
    m1.cpu_req = 0; m1.cpu_rnw = 1; m1.cpu_addr = '0; m1.cpu_wdata = '0;
    m1.dma_req = 0; m1.dma_rnw = 1; m1.dma_addr = '0; m1.dma_wdata = '0;
    ram0[12'h010] = 24'h00ABCD;
    ram0[12'h020] = 24'h000555;
    ram0[12'h030] = 24'h000BAD;
    ram1[12'h005] = 24'h111111;
    ram1[12'h006] = 24'h222222;

    // Reset values
    tick();
    check_bit ("rst_mem_cs",    m0.mem_cs,  1'b0);
    check_bit ("rst_mem_rnw",   m0.mem_rnw, 1'b1);
    check_word("rst_mem_addr",  32'(m0.mem_addr),  32'h0);
    check_word("rst_mem_wdata", 32'(m0.mem_wdata), 32'h0);
    check_bit ("rst_cpu_ack",   m0.cpu_ack, 1'b0);
    check_bit ("rst_dma_ack",   m0.dma_ack, 1'b0);
    check_word("rst_cpu_rdata", 32'(m0.cpu_rdata), 32'h0);
    check_word("rst_dma_rdata", 32'(m0.dma_rdata), 32'h0);
    check_bit ("rst_busy",      m0.busy,  1'b0);
    check_bit ("rst_owner",     m0.owner, 1'b1);
    reset = 1'b1;
    tick();

    // CPU read of 0x010
    m0.cpu_req = 1; m0.cpu_rnw = 1; m0.cpu_addr = 12'h010;
    tick();
    check_bit ("rd_cs_1",    m0.mem_cs,  1'b1);
    check_bit ("rd_rnw",     m0.mem_rnw, 1'b1);
    check_word("rd_addr",    32'(m0.mem_addr), 32'h010);
    check_bit ("rd_owner",   m0.owner, 1'b0);
    check_bit ("rd_busy",    m0.busy,  1'b1);
    check_bit ("rd_no_ack",  m0.cpu_ack, 1'b0);
    tick();
    check_bit ("rd_cs_2",    m0.mem_cs, 1'b1);
    check_bit ("rd_no_ack2", m0.cpu_ack, 1'b0);
    tick();
    check_bit ("rd_cs_off",  m0.mem_cs, 1'b0);
    check_bit ("rd_ack",     m0.cpu_ack, 1'b1);
    check_bit ("rd_dma_ack", m0.dma_ack, 1'b0);
    check_word("rd_rdata",   32'(m0.cpu_rdata), 32'h00ABCD);
    m0.cpu_req = 0;
    tick();
    check_bit ("rd_ack_end", m0.cpu_ack, 1'b0);
    check_bit ("rd_idle",    m0.busy, 1'b0);

    // DMA write 0x123456 to 0x7FF
    m0.dma_req = 1; m0.dma_rnw = 0; m0.dma_addr = 12'h7FF; m0.dma_wdata = 24'h123456;
    tick();
    check_bit ("wr_cs",    m0.mem_cs,  1'b1);
    check_bit ("wr_rnw",   m0.mem_rnw, 1'b0);
    check_word("wr_addr",  32'(m0.mem_addr),  32'h7FF);
    check_word("wr_wdata", 32'(m0.mem_wdata), 32'h123456);
    check_bit ("wr_owner", m0.owner, 1'b1);
    tick();
    tick();
    check_bit ("wr_dma_ack", m0.dma_ack, 1'b1);
    check_bit ("wr_cpu_ack", m0.cpu_ack, 1'b0);
    check_word("wr_cpu_rdata_kept", 32'(m0.cpu_rdata), 32'h00ABCD);
    check_word("wr_dma_rdata_kept", 32'(m0.dma_rdata), 32'h0);
    check_word("wr_ram", 32'(ram0[12'h7FF]), 32'h123456);
    m0.dma_req = 0;
    tick();
    check_bit ("wr_ack_end", m0.dma_ack, 1'b0);

    // CPU request dropped and address changed after grant
    m0.cpu_req = 1; m0.cpu_rnw = 1; m0.cpu_addr = 12'h020;
    tick();
    m0.cpu_req = 0; m0.cpu_addr = 12'h030;
    check_word("drop_addr_1", 32'(m0.mem_addr), 32'h020);
    tick();
    check_word("drop_addr_2", 32'(m0.mem_addr), 32'h020);
    tick();
    check_bit ("drop_ack",   m0.cpu_ack, 1'b1);
    check_word("drop_rdata", 32'(m0.cpu_rdata), 32'h000555);
    tick();
    check_bit ("drop_idle",  m0.busy, 1'b0);

    // Reset mid-access
    m0.cpu_req = 1; m0.cpu_rnw = 1; m0.cpu_addr = 12'h010;
    tick();
    check_bit ("mid_cs_on", m0.mem_cs, 1'b1);
    reset = 1'b0;
    #1;
    check_bit ("mid_rst_cs",    m0.mem_cs, 1'b0);
    check_bit ("mid_rst_owner", m0.owner,  1'b1);
    check_bit ("mid_rst_busy",  m0.busy,   1'b0);
    m0.cpu_req = 0;
    tick();
    check_bit ("mid_rst_noack", m0.cpu_ack, 1'b0);
    check_word("mid_rst_rdata", 32'(m0.cpu_rdata), 32'h0);

    // Both requesting from reset
    m0.cpu_req = 1; m0.cpu_rnw = 1; m0.cpu_addr = 12'h010;
    m0.dma_req = 1; m0.dma_rnw = 1; m0.dma_addr = 12'h7FF;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = !PRIO && k[0];
      tick();
      tick();
      check_bit("tie_pre_cpu_ack", m0.cpu_ack, 1'b0);
      check_bit("tie_pre_dma_ack", m0.dma_ack, 1'b0);
      tick();
      check_bit ("tie_cpu_ack", m0.cpu_ack, !exp_d);
      check_bit ("tie_dma_ack", m0.dma_ack, exp_d);
      check_word("tie_cpu_rdata", 32'(m0.cpu_rdata), 32'h00ABCD);
      check_word("tie_dma_rdata", 32'(m0.dma_rdata), (!PRIO && k >= 1) ? 32'h123456 : 32'h0);
      tick();
      check_bit("tie_post_cpu_ack", m0.cpu_ack, 1'b0);
      check_bit("tie_post_dma_ack", m0.dma_ack, 1'b0);
    end
    m0.cpu_req = 0; m0.dma_req = 0;

    // ACCESS_CYCLES=1: ack one edge after grant, back-to-back reads 3 cycles apart
    m1.cpu_req = 1; m1.cpu_rnw = 1; m1.cpu_addr = 12'h005;
    tick();
    check_bit("ac1_cs",      m1.mem_cs,  1'b1);
    check_bit("ac1_no_ack",  m1.cpu_ack, 1'b0);
    tick();
    check_bit ("ac1_ack1",   m1.cpu_ack, 1'b1);
    check_bit ("ac1_cs_off", m1.mem_cs,  1'b0);
    check_word("ac1_rdata1", 32'(m1.cpu_rdata), 32'h111111);
    m1.cpu_addr = 12'h006;
    tick();
    check_bit("ac1_gap1", m1.cpu_ack, 1'b0);
    tick();
    check_bit ("ac1_gap2",  m1.cpu_ack, 1'b0);
    check_word("ac1_addr2", 32'(m1.mem_addr), 32'h006);
    tick();
    check_bit ("ac1_ack2",   m1.cpu_ack, 1'b1);
    check_word("ac1_rdata2", 32'(m1.cpu_rdata), 32'h222222);
    m1.cpu_req = 0;
    tick();
    check_bit("ac1_end", m1.busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
